// File: rtl/result_stream_reader_pkg.sv
// Shared constants for the result stream reader: register map, bit
// positions inside STATUS/CONTROL, and the capture state encoding.
package result_stream_reader_pkg;

  // Avalon-MM word addresses
  localparam logic [2:0] ADDR_STATUS      = 3'd0;
  localparam logic [2:0] ADDR_LEVEL       = 3'd1;
  localparam logic [2:0] ADDR_DATA_LO     = 3'd2;
  localparam logic [2:0] ADDR_DATA_HI     = 3'd3;
  localparam logic [2:0] ADDR_CONTROL     = 3'd4;
  localparam logic [2:0] ADDR_CAPTURE_LEN = 3'd5;
  localparam logic [2:0] ADDR_CAPTURED    = 3'd6;
  localparam logic [2:0] ADDR_RSVD        = 3'd7;

  // STATUS bit positions
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 3;
  localparam int ST_DONE      = 4;
  localparam int ST_STATE_LSB = 5;

  // CONTROL bit positions
  localparam int CTL_START  = 0;
  localparam int CTL_FLUSH  = 1;
  localparam int CTL_STOP   = 2;
  localparam int CTL_IRQ_EN = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry, so a
// read on the cycle after a pop sees the next entry. Flush overrides push
// and pop issued in the same cycle.
module result_fifo #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == (ADDR_W + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted pushes only.
  // NOTE: the array has no reset; pointers/level define validity, and a
  // resettable array would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and fill level; reset and flush both return to empty.
  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/result_stream_reader.sv
// Captures the 64-bit processed-result stream into a FIFO and exposes it to
// the control processor over a 32-bit Avalon-MM slave with read latency 1.
module result_stream_reader
  import result_stream_reader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              processing_finished,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic              irq
);

  state_t            state;
  logic [31:0]       captured;
  logic [31:0]       captured_next;
  logic [31:0]       capture_len;
  logic [31:0]       hold;
  logic              irq_en;
  logic              overflow;
  logic              underflow;
  logic              pf_d;
  logic              pf_rise;

  logic              ctl_start;
  logic              ctl_flush;
  logic              ctl_stop;
  logic              rd_lo;
  logic              rd_hi;
  logic [31:0]       rd_mux;

  logic              push_req;
  logic              accept;
  logic [DATA_W-1:0] fifo_dout;
  logic [ADDR_W:0]   fifo_level;
  logic              fifo_full;
  logic              fifo_empty;

  // Full is the pre-edge level, so a sample arriving while full is dropped
  // even when a pop happens in the same cycle.
  assign push_req      = (state == S_CAPTURE) && enable && data_in_valid;
  assign accept        = push_req && !fifo_full && !ctl_flush;
  assign captured_next = accept ? captured + 32'd1 : captured;
  assign pf_rise       = processing_finished && !pf_d;

  result_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (rd_hi),
    .flush   (ctl_flush),
    .din     (data_in),
    .dout    (fifo_dout),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Bus decode: control pulses, data-port strobes and the read-data mux.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    ctl_start = 1'b0;
    ctl_flush = 1'b0;
    ctl_stop  = 1'b0;
    rd_lo     = 1'b0;
    rd_hi     = 1'b0;
    rd_mux    = '0;
    if (avs_write && (avs_address == ADDR_CONTROL)) begin
      ctl_start = avs_writedata[CTL_START];
      ctl_flush = avs_writedata[CTL_FLUSH];
      ctl_stop  = avs_writedata[CTL_STOP];
    end
    if (avs_read && (avs_address == ADDR_DATA_LO)) rd_lo = 1'b1;
    if (avs_read && (avs_address == ADDR_DATA_HI)) rd_hi = 1'b1;
    case (avs_address)
      ADDR_STATUS: begin
        rd_mux[ST_EMPTY]               = fifo_empty;
        rd_mux[ST_FULL]                = fifo_full;
        rd_mux[ST_OVERFLOW]            = overflow;
        rd_mux[ST_UNDERFLOW]           = underflow;
        rd_mux[ST_DONE]                = (state == S_DONE);
        rd_mux[ST_STATE_LSB +: 2]      = state;
      end
      ADDR_LEVEL:       rd_mux = 32'(fifo_level);
      ADDR_DATA_LO:     rd_mux = fifo_empty ? '0 : fifo_dout[31:0];
      ADDR_DATA_HI:     rd_mux = hold;
      ADDR_CONTROL:     rd_mux[CTL_IRQ_EN] = irq_en;
      ADDR_CAPTURE_LEN: rd_mux = capture_len;
      ADDR_CAPTURED:    rd_mux = captured;
      ADDR_RSVD:        rd_mux = '0;
    endcase
  end

  // Capture FSM, counters, sticky flags, register file and bus outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      captured     <= '0;
      capture_len  <= '0;
      hold         <= '0;
      irq_en       <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      pf_d         <= 1'b0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      pf_d <= processing_finished;
      irq  <= irq_en && (state == S_DONE) && !fifo_empty;

      if (avs_read) avs_readdata <= rd_mux;

      if (avs_write && (avs_address == ADDR_CAPTURE_LEN)) capture_len <= avs_writedata;
      if (avs_write && (avs_address == ADDR_CONTROL))     irq_en <= avs_writedata[CTL_IRQ_EN];

      // DATA_LO latches the upper half; an empty read zeroes it instead.
      if (rd_lo) begin
        if (fifo_empty) begin
          hold      <= '0;
          underflow <= 1'b1;
        end else begin
          hold <= fifo_dout[DATA_W-1:32];
        end
      end
      if (rd_hi && fifo_empty) underflow <= 1'b1;

      if (push_req && fifo_full) overflow <= 1'b1;
      captured <= captured_next;

      if (state == S_CAPTURE) begin
        if (pf_rise || ((capture_len != '0) && (captured_next >= capture_len)))
          state <= S_DONE;
      end

      if (ctl_start) begin
        state    <= S_CAPTURE;
        captured <= '0;
      end
      if (ctl_stop) state <= S_IDLE;

      // Flush wins over any same-cycle flag update or hold latch.
      if (ctl_flush) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
        hold      <= '0;
      end
    end
  end

endmodule

// File: doc/result_stream_reader.md
Name: result_stream_reader

Overview:
- Consumer-side end of the 64-bit processed-result stream (data/valid pair) produced by the signal-processing chain.
- Captures result samples into an on-chip FIFO.
- Exposes them to the Nios control processor through a 32-bit Avalon-MM slave: status, fill level, split low/high data reads, capture control.
- Sits between the signal-processing outputs and the control system. The control system drains processed results word by word instead of sampling a single live register.

Parameters:
- DEPTH, 1024, FIFO entries (power of two, ≥4).
- ADDR_W, 10, log2(DEPTH).
- DATA_W, 64, stream sample width (fixed 64; the low/high split assumes it).

Ports:
- clk, in, 1, single clock (processing clock domain).
- reset_n, in, 1, reset, synchronous, active-low.
- enable, in, 1, general enable; samples accepted only when high.
- data_in, in, 64, result sample.
- data_in_valid, in, 1, sample strobe, one sample per high cycle.
- processing_finished, in, 1, end-of-calculation flag from processing chain.
- avs_address, in, 3, register select.
- avs_read, in, 1, read strobe.
- avs_readdata, out, 32, read data, fixed read latency 1.
- avs_write, in, 1, write strobe.
- avs_writedata, in, 32, write data.
- irq, out, 1, level interrupt to control processor.

Behaviour:
- Reset (sync, reset_n low at clk edge):
  - State IDLE, pointers and level 0.
  - Sticky bits, captured counter, CAPTURE_LEN, irq_en and hold register all 0.
  - avs_readdata = 0, irq = 0.
  - Reset mid-capture discards FIFO contents.
- States:
  - IDLE: no push.
  - CAPTURE: push when enable && data_in_valid.
  - DONE: no push.
- Transitions:
  - CONTROL.start (bit0 write 1): any state -> CAPTURE; clears captured counter.
  - CONTROL.stop (bit2): any -> IDLE.
  - CAPTURE -> DONE when captured counter reaches CAPTURE_LEN (CAPTURE_LEN ≠ 0), or on the rising edge of processing_finished.
  - CAPTURE_LEN = 0 means unlimited; only processing_finished or stop ends capture.
- Push:
  - Full is evaluated on the pre-edge level.
  - A valid sample while full is dropped, sets OVERFLOW sticky, and does not increment the captured counter, even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full: level unchanged.
- Register map (word address):
  - 0 STATUS (R): bit0 empty, bit1 full, bit2 overflow, bit3 underflow, bit4 done, bits[6:5] state encoding.
  - 1 LEVEL (R): zero-extended fill count 0..DEPTH.
  - 2 DATA_LO (R): returns head[31:0] and latches head[63:32] into the hold register. No pop.
  - 3 DATA_HI (R): returns hold register and pops the head entry.
  - 4 CONTROL (W): bit0 start, bit1 flush, bit2 stop, bit3 irq_en (stored). Bits 0–2 are self-clearing pulses. Reads return {28'b0, irq_en, 3'b0}.
  - 5 CAPTURE_LEN (R/W): 32-bit target sample count.
  - 6 CAPTURED (R): samples accepted since last start.
  - 7: reads 0.
- Read access:
  - avs_readdata is registered and valid the cycle after avs_read; it holds the value otherwise.
  - DATA_LO read when empty: returns 0, hold = 0, sets UNDERFLOW sticky.
  - DATA_HI read when empty: returns hold, no pop, sets UNDERFLOW sticky.
  - Reads of other registers have no side effects.
- Flush (CONTROL bit1):
  - Empties the FIFO and clears OVERFLOW, UNDERFLOW and the hold register.
  - State is unchanged.
  - Flush wins over a same-cycle push or pop; that push is dropped without setting OVERFLOW.
- Start and flush in the same write: both apply (empty FIFO, CAPTURE).
- irq = irq_en && (state == DONE) && !empty, registered, so asserted 1 cycle after its condition becomes true.
- The FIFO head is show-ahead: after a DATA_HI pop, the next entry is valid for a DATA_LO read issued on the following cycle (back-to-back reads supported).

Decomposition:
- Package result_stream_reader_pkg:
  - Register address constants 0–7.
  - STATUS/CONTROL bit indices.
  - State encoding IDLE=0, CAPTURE=1, DONE=2.
- Sub-module result_fifo: synchronous show-ahead FIFO with ports push, pop, flush, din, dout, level, full, empty, parameterised by DEPTH/DATA_W.
- The top level holds the FSM, counters, register file and Avalon slave.

Test Plan:
- Reset, then read STATUS -> 0x00000001 (empty), LEVEL = 0, irq = 0; start with CAPTURE_LEN = 3, stream 0x11111111_22222222, 0x3..., 0x5... -> LEVEL = 3, CAPTURED = 3, STATUS.done = 1, fourth valid sample ignored (LEVEL stays 3).
- Drain: DATA_LO -> 0x22222222, DATA_HI -> 0x11111111; repeat 3 times -> LEVEL = 0, empty = 1; a further DATA_LO -> 0, underflow = 1.
- Overflow: CAPTURE_LEN = 0, push DEPTH+2 samples -> LEVEL = 1024, full = 1, overflow = 1, CAPTURED = 1024; flush -> LEVEL = 0, overflow = 0, state still CAPTURE.
- irq_en = 1 with 2 samples pushed, then processing_finished pulses -> irq high 1 cycle after DONE; drain both entries -> irq low.
- Push and pop in the same cycle at LEVEL = 5 -> LEVEL stays 5, order preserved; flush with a coincident push -> LEVEL = 0, overflow = 0.
- Assert reset_n low for 1 cycle mid-capture at LEVEL = 7 -> LEVEL = 0, state IDLE, CAPTURE_LEN = 0; valid samples afterwards not accepted until start.
